// File: rtl/rcv_deframer.sv
// Receive deframer: strips commas, pulses triggers, re-frames CW-delimited blocks, flags structure errors.
// Latency: a word at the inputs in cycle N drives outputs in cycle N+2 (input register + output register).
// Backpressure: none; the link runs at line rate and every output is a pulse or a valid-qualified word.
module rcv_deframer #(
   parameter int ERRW = 16,
   parameter int BLKW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_ok,
   input  logic [15:0]     rxdata,
   input  logic            rxkchar,
   output logic            trig,
   output logic [15:0]     dout,
   output logic            dvalid,
   output logic            dsop,
   output logic            deop,
   output logic            dabort,
   output logic            err_undr,
   output logic            err_ovr,
   output logic            err_kchar,
   output logic [BLKW-1:0] cnt_blk,
   output logic [ERRW-1:0] cnt_err
);

   localparam logic [15:0] K_COMMA = 16'h00BC;
   localparam logic [15:0] K_TRIG  = 16'h801C;

   typedef enum logic {IDLE, BLOCK} state_t;

   // registered link inputs
   logic        in_ok;
   logic        in_k;
   logic [15:0] in_dat;

   // block tracking
   state_t      state, state_nx;
   logic [8:0]  rem, rem_nx;

   // next values for the registered outputs
   logic        trig_nx, dvalid_nx, dsop_nx, deop_nx, dabort_nx;
   logic        undr_nx, ovr_nx, kerr_nx, blk_inc;
   logic [15:0] dout_nx;

   // word classification of the registered input word
   logic        is_comma, is_trig, is_unk, is_cw, is_data;
   logic [8:0]  cw_len;

   assign is_comma = in_k && (in_dat == K_COMMA);
   assign is_trig  = in_k && (in_dat == K_TRIG);
   assign is_unk   = in_k && !is_comma && !is_trig;
   assign is_cw    = !in_k && in_dat[15];
   assign is_data  = !in_k && !in_dat[15];
   assign cw_len   = in_dat[8:0];

   // input register stage; rx_ok is cleared on reset so nothing is decoded until the link reports lock
   always_ff @(posedge clk) begin
      if (reset) begin
         in_ok  <= 1'b0;
         in_k   <= 1'b0;
         in_dat <= '0;
      end else begin
         in_ok  <= rx_ok;
         in_k   <= rxkchar;
         in_dat <= rxdata;
      end
   end

   // state and remaining-word register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         rem   <= '0;
      end else begin
         state <= state_nx;
         rem   <= rem_nx;
      end
   end

   // next-state: CWs always (re)open a block, data counts rem down, link loss or unknown K closes the block
   always_comb begin
      state_nx = state;
      rem_nx   = rem;
      if (!in_ok) begin
         state_nx = IDLE;
         rem_nx   = '0;
      end else if (is_cw) begin
         rem_nx   = cw_len;
         state_nx = (cw_len == 9'd0) ? IDLE : BLOCK;
      end else if (state == BLOCK) begin
         if (is_data) begin
            // rem is always >= 1 while in BLOCK; the guard keeps it from wrapping regardless
            rem_nx = (rem != 9'd0) ? rem - 9'd1 : 9'd0;
            if (rem == 9'd1) begin
               state_nx = IDLE;
            end
         end else if (is_unk) begin
            state_nx = IDLE;
            rem_nx   = '0;
         end
      end
   end

   // output decode: what the registered outputs show next cycle for the current word
   always_comb begin
      trig_nx   = 1'b0;
      dvalid_nx = 1'b0;
      dsop_nx   = 1'b0;
      deop_nx   = 1'b0;
      dabort_nx = 1'b0;
      undr_nx   = 1'b0;
      ovr_nx    = 1'b0;
      kerr_nx   = 1'b0;
      blk_inc   = 1'b0;
      dout_nx   = '0;
      if (!in_ok) begin
         // link lost: everything is ignored, only the open block gets abandoned
         dabort_nx = (state == BLOCK);
      end else begin
         trig_nx = is_trig;
         if (is_cw) begin
            dvalid_nx = 1'b1;
            dsop_nx   = 1'b1;
            dout_nx   = in_dat;
            // a zero-length block completes on its own CW
            deop_nx   = (cw_len == 9'd0);
            blk_inc   = (cw_len == 9'd0);
            // a CW inside a block abandons the old block; the abort refers to the old block,
            // any deop on this cycle refers to the new zero-length one
            if (state == BLOCK) begin
               undr_nx   = 1'b1;
               dabort_nx = 1'b1;
            end
         end else if (is_data) begin
            if (state == BLOCK) begin
               dvalid_nx = 1'b1;
               dout_nx   = in_dat;
               deop_nx   = (rem == 9'd1);
               blk_inc   = (rem == 9'd1);
            end else begin
               ovr_nx = 1'b1;
            end
         end else if (is_unk) begin
            kerr_nx   = 1'b1;
            dabort_nx = (state == BLOCK);
         end
      end
   end

   // registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         trig      <= 1'b0;
         dout      <= '0;
         dvalid    <= 1'b0;
         dsop      <= 1'b0;
         deop      <= 1'b0;
         dabort    <= 1'b0;
         err_undr  <= 1'b0;
         err_ovr   <= 1'b0;
         err_kchar <= 1'b0;
      end else begin
         trig      <= trig_nx;
         dout      <= dout_nx;
         dvalid    <= dvalid_nx;
         dsop      <= dsop_nx;
         deop      <= deop_nx;
         dabort    <= dabort_nx;
         err_undr  <= undr_nx;
         err_ovr   <= ovr_nx;
         err_kchar <= kerr_nx;
      end
   end

   // completed-block counter wraps; error counter counts error cycles and sticks at all-ones
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_blk <= '0;
         cnt_err <= '0;
      end else begin
         if (blk_inc) begin
            cnt_blk <= cnt_blk + 1'b1;
         end
         if ((undr_nx || ovr_nx || kerr_nx) && !(&cnt_err)) begin
            cnt_err <= cnt_err + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rcv_deframer.sv
// Directed table-driven bench for rcv_deframer (ERRW=4 build so saturation is reachable).
// Each row holds one input word and the flags expected two clocks later.
// Rows are checked in order; counters are checked by hand after each sequence.
module tb_rcv_deframer;

   localparam int ERRW = 4;
   localparam int BLKW = 32;

   // expected-flag bits: {trig,dvalid,dsop,deop,dabort,err_undr,err_ovr,err_kchar}
   localparam logic [7:0] T = 8'h80;
   localparam logic [7:0] V = 8'h40;
   localparam logic [7:0] S = 8'h20;
   localparam logic [7:0] E = 8'h10;
   localparam logic [7:0] A = 8'h08;
   localparam logic [7:0] U = 8'h04;
   localparam logic [7:0] O = 8'h02;
   localparam logic [7:0] K = 8'h01;
   localparam logic [7:0] Z = 8'h00;

   logic            clk = 1'b0;
   logic            reset;
   logic            rx_ok;
   logic [15:0]     rxdata;
   logic            rxkchar;
   logic            trig, dvalid, dsop, deop, dabort, err_undr, err_ovr, err_kchar;
   logic [15:0]     dout;
   logic [BLKW-1:0] cnt_blk;
   logic [ERRW-1:0] cnt_err;

   rcv_deframer #(.ERRW(ERRW), .BLKW(BLKW)) dut (
      .clk(clk), .reset(reset), .rx_ok(rx_ok), .rxdata(rxdata), .rxkchar(rxkchar),
      .trig(trig), .dout(dout), .dvalid(dvalid), .dsop(dsop), .deop(deop), .dabort(dabort),
      .err_undr(err_undr), .err_ovr(err_ovr), .err_kchar(err_kchar),
      .cnt_blk(cnt_blk), .cnt_err(cnt_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ok;
      logic        k;
      logic [15:0] d;
      logic [7:0]  f;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic void add(input logic ok, input logic k, input logic [15:0] d, input logic [7:0] f);
      vec_t v;
      v.ok = ok; v.k = k; v.d = d; v.f = f;
      vecs.push_back(v);
   endfunction

   function automatic logic [7:0] flags();
      return {trig, dvalid, dsop, deop, dabort, err_undr, err_ovr, err_kchar};
   endfunction

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // dout is only compared when a valid word is expected; it then equals the input word
   task automatic check_row(input string tag, input int idx, input vec_t v);
      logic [7:0] got;
      got = flags();
      n_vec++;
      if (got !== v.f || (v.f[6] && dout !== v.d)) begin
         n_bad++;
         $display("FAIL %s row %0d: flags %b dout %h, expected flags %b dout %h",
                  tag, idx, got, dout, v.f, v.d);
      end
   endtask

   // row i is driven in iteration i and its outputs are sampled after the edge of iteration i+1
   task automatic run_table(input string tag);
      int n;
      n = vecs.size();
      for (int i = 0; i <= n; i++) begin
         if (i < n) begin
            rx_ok = vecs[i].ok; rxkchar = vecs[i].k; rxdata = vecs[i].d;
         end else begin
            rx_ok = 1'b1; rxkchar = 1'b1; rxdata = 16'h00BC;
         end
         @(posedge clk); #1;
         if (i >= 1) check_row(tag, i - 1, vecs[i-1]);
      end
      vecs.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1; rx_ok = 1'b0; rxkchar = 1'b0; rxdata = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      check_val("reset_flags", {24'd0, flags()}, 32'd0);
      check_val("reset_dout", {16'd0, dout}, 32'd0);
      check_val("reset_cnt_blk", cnt_blk, 32'd0);
      check_val("reset_cnt_err", {28'd0, cnt_err}, 32'd0);

      // basic block with commas interleaved
      add(1, 1, 16'h00BC, Z);
      add(1, 1, 16'h00BC, Z);
      add(1, 0, 16'h8003, V | S);
      add(1, 0, 16'h0001, V);
      add(1, 1, 16'h00BC, Z);
      add(1, 0, 16'h0002, V);
      add(1, 1, 16'h00BC, Z);
      add(1, 0, 16'h0003, V | E);
      run_table("basic");
      check_val("basic_cnt_blk", cnt_blk, 32'd1);
      check_val("basic_cnt_err", {28'd0, cnt_err}, 32'd0);

      // zero-length block stays IDLE, so the next data word overflows
      add(1, 0, 16'h8000, V | S | E);
      add(1, 0, 16'h0011, O);
      run_table("zero_len");
      check_val("zero_len_cnt_blk", cnt_blk, 32'd2);
      check_val("zero_len_cnt_err", {28'd0, cnt_err}, 32'd1);

      // trigger inside a block
      do_reset();
      add(1, 0, 16'h8002, V | S);
      add(1, 0, 16'h0007, V);
      add(1, 1, 16'h801C, T);
      add(1, 0, 16'h0008, V | E);
      add(1, 1, 16'h801C, T);
      run_table("trig");
      check_val("trig_cnt_blk", cnt_blk, 32'd1);

      // underrun: new CW while data still expected
      do_reset();
      add(1, 0, 16'h8004, V | S);
      add(1, 0, 16'h0001, V);
      add(1, 0, 16'h0002, V);
      add(1, 0, 16'h8001, V | S | U | A);
      add(1, 0, 16'h0009, V | E);
      run_table("underrun");
      check_val("underrun_cnt_err", {28'd0, cnt_err}, 32'd1);
      check_val("underrun_cnt_blk", cnt_blk, 32'd1);

      // overrun in IDLE, unknown K mid-block, unknown K in IDLE
      do_reset();
      add(1, 0, 16'h0055, O);
      add(1, 0, 16'h8003, V | S);
      add(1, 0, 16'h0001, V);
      add(1, 1, 16'h00FC, K | A);
      add(1, 0, 16'h0002, O);
      add(1, 0, 16'h0003, O);
      add(1, 1, 16'h0123, K);
      run_table("kchar");
      check_val("kchar_cnt_err", {28'd0, cnt_err}, 32'd5);
      check_val("kchar_cnt_blk", cnt_blk, 32'd0);

      // link loss mid-block: one abort, everything suppressed while low
      do_reset();
      add(1, 0, 16'h8003, V | S);
      add(1, 0, 16'h0001, V);
      add(0, 1, 16'h801C, A);
      add(0, 0, 16'h0002, Z);
      add(0, 1, 16'h00FC, Z);
      add(1, 0, 16'h0003, O);
      run_table("rx_ok");
      check_val("rx_ok_cnt_err", {28'd0, cnt_err}, 32'd1);

      // error counter saturates at 15
      do_reset();
      for (int i = 0; i < 20; i++) add(1, 0, 16'h0001, O);
      run_table("sat");
      check_val("sat_cnt_err", {28'd0, cnt_err}, 32'd15);

      // largest block: CW with L=511 followed by 511 data words
      do_reset();
      add(1, 0, 16'h81FF, V | S);
      for (int i = 1; i < 511; i++) add(1, 0, 16'(i & 16'h7FFF), V);
      add(1, 0, 16'h01FF, V | E);
      add(1, 0, 16'h0042, O);
      run_table("max_blk");
      check_val("max_blk_cnt_blk", cnt_blk, 32'd1);

      // reset mid-block: no abort, no eop, and the block is gone afterwards
      do_reset();
      add(1, 0, 16'h8003, V | S);
      add(1, 0, 16'h0001, V);
      run_table("mid_reset_pre");
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val("mid_reset_abort_eop", {30'd0, dabort, deop}, 32'd0);
      end
      reset = 1'b0;
      add(1, 0, 16'h0005, O);
      run_table("mid_reset_post");
      check_val("mid_reset_cnt_blk", cnt_blk, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
